// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read RAM between the fetch and load/store ports,
// data first, with a starvation counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_imem_req_valid,
  output logic              io_imem_req_ready,
  input  logic [31:0]       io_imem_req_addr,
  output logic              io_imem_resp_valid,
  output logic [31:0]       io_imem_resp_inst,
  input  logic              io_dmem_req_valid,
  output logic              io_dmem_req_ready,
  input  logic [31:0]       io_dmem_req_addr,
  input  logic              io_dmem_req_wen,
  input  logic [31:0]       io_dmem_req_wdata,
  input  logic [3:0]        io_dmem_req_wstrb,
  output logic              io_dmem_resp_valid,
  output logic [31:0]       io_dmem_resp_rdata,
  output logic              io_dmem_resp_err,
  output logic              io_ram_en,
  output logic              io_ram_wen,
  output logic [ADDR_W-1:0] io_ram_addr,
  output logic [31:0]       io_ram_wdata,
  output logic [3:0]        io_ram_wstrb,
  input  logic [31:0]       io_ram_rdata
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic        cnt, cnt_nx;
  logic        own_d, own_d_nx;
  logic [3:0]  starve, starve_nx;
  logic [31:0] inst, rdata;
  logic        err;
  logic        elig, force_i, gnt_i, gnt_d, mis, d_rd;
  logic        unused;
  assign unused = ^{io_imem_req_addr[31:ADDR_W], io_imem_req_addr[1:0], io_dmem_req_addr[31:ADDR_W]};
  always_comb begin
    elig      = state != RD_WAIT;
    force_i   = starve == 4'(STARVE_LIMIT) && io_imem_req_valid;
    gnt_d     = elig && io_dmem_req_valid && !force_i;
    gnt_i     = elig && io_imem_req_valid && !gnt_d;
    mis       = io_dmem_req_addr[1:0] != 2'b00;
    d_rd      = gnt_d && !mis && !io_dmem_req_wen;
    io_imem_req_ready = gnt_i;
    io_dmem_req_ready = gnt_d;
    io_ram_en    = gnt_i || (gnt_d && !mis);
    io_ram_wen   = gnt_d && !mis && io_dmem_req_wen;
    io_ram_addr  = !io_ram_en ? '0 :
                   gnt_d ? {io_dmem_req_addr[ADDR_W-1:2], 2'b00} : {io_imem_req_addr[ADDR_W-1:2], 2'b00};
    io_ram_wdata = io_ram_en ? io_dmem_req_wdata : '0;
    io_ram_wstrb = io_ram_wen ? io_dmem_req_wstrb : 4'h0;
    io_imem_resp_valid = state == RESP && !own_d;
    io_dmem_resp_valid = state == RESP && own_d;
    io_imem_resp_inst  = inst;
    io_dmem_resp_rdata = rdata;
    io_dmem_resp_err   = err;
    state_nx  = state;
    cnt_nx    = cnt;
    own_d_nx  = own_d;
    starve_nx = gnt_i ? 4'h0 :
                !gnt_d ? starve :
                !io_imem_req_valid ? 4'h0 :
                starve + 4'(starve != 4'(STARVE_LIMIT));
    if (state == RD_WAIT) begin
      state_nx = cnt ? RD_WAIT : RESP;
      cnt_nx   = 1'b0;
    end else if (gnt_i || d_rd) begin
      state_nx = RD_WAIT;
      cnt_nx   = 1'(READ_LAT - 1);
      own_d_nx = gnt_d;
    end else if (gnt_d) begin
      state_nx = RESP;
      own_d_nx = 1'b1;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 1'b0;
      own_d  <= 1'b0;
      starve <= 4'h0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      own_d  <= own_d_nx;
      starve <= starve_nx;
    end
  end
  // Response data is captured on the last wait cycle so it holds until the next response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inst  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else if (state == RD_WAIT && !cnt) begin
      if (own_d) begin
        rdata <= io_ram_rdata;
        err   <= 1'b0;
      end else begin
        inst <= io_ram_rdata;
      end
    end else if (gnt_d && !d_rd) begin
      rdata <= '0;
      err   <= mis;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for the RAM arbiter, with READ_LAT=1 and READ_LAT=2 instances
// each attached to its own behavioural RAM.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        iv = 1'b0, dv = 1'b0, dwen = 1'b0;
  logic [31:0] ia = '0, da = '0, dwd = '0;
  logic [3:0]  dws = '0;

  logic        ri1, rvi1, rd1, rvd1, err1, en1, wen1;
  logic [31:0] inst1, rdata1, wdata1, ram_rd1;
  logic [10:0] addr1;
  logic [3:0]  wstrb1;
  logic        ri2, rvi2, rd2, rvd2, err2, en2, wen2;
  logic [31:0] inst2, rdata2, wdata2, ram_rd2, pipe2;
  logic [10:0] addr2;
  logic [3:0]  wstrb2;

  logic [31:0] mem1 [512];
  logic [31:0] mem2 [512];

  mem_port_arbiter #(.ADDR_W(11), .READ_LAT(1), .STARVE_LIMIT(4)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .io_imem_req_valid(iv), .io_imem_req_ready(ri1), .io_imem_req_addr(ia),
    .io_imem_resp_valid(rvi1), .io_imem_resp_inst(inst1),
    .io_dmem_req_valid(dv), .io_dmem_req_ready(rd1), .io_dmem_req_addr(da),
    .io_dmem_req_wen(dwen), .io_dmem_req_wdata(dwd), .io_dmem_req_wstrb(dws),
    .io_dmem_resp_valid(rvd1), .io_dmem_resp_rdata(rdata1), .io_dmem_resp_err(err1),
    .io_ram_en(en1), .io_ram_wen(wen1), .io_ram_addr(addr1), .io_ram_wdata(wdata1),
    .io_ram_wstrb(wstrb1), .io_ram_rdata(ram_rd1));

  mem_port_arbiter #(.ADDR_W(11), .READ_LAT(2), .STARVE_LIMIT(4)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .io_imem_req_valid(iv), .io_imem_req_ready(ri2), .io_imem_req_addr(ia),
    .io_imem_resp_valid(rvi2), .io_imem_resp_inst(inst2),
    .io_dmem_req_valid(dv), .io_dmem_req_ready(rd2), .io_dmem_req_addr(da),
    .io_dmem_req_wen(dwen), .io_dmem_req_wdata(dwd), .io_dmem_req_wstrb(dws),
    .io_dmem_resp_valid(rvd2), .io_dmem_resp_rdata(rdata2), .io_dmem_resp_err(err2),
    .io_ram_en(en2), .io_ram_wen(wen2), .io_ram_addr(addr2), .io_ram_wdata(wdata2),
    .io_ram_wstrb(wstrb2), .io_ram_rdata(ram_rd2));

  // RAM contents are (re)seeded while reset is held.
  always @(posedge clock) begin
    if (!reset_n) begin
      mem1[64] <= 32'h00000013;
      mem2[0]  <= 32'h11111111;
      mem2[1]  <= 32'h22222222;
    end else begin
      if (en1 && wen1) begin
        for (int b = 0; b < 4; b++)
          if (wstrb1[b]) mem1[addr1[10:2]][8*b +: 8] <= wdata1[8*b +: 8];
      end else if (en1) begin
        ram_rd1 <= mem1[addr1[10:2]];
      end
      if (en2 && !wen2) pipe2 <= mem2[addr2[10:2]];
      ram_rd2 <= pipe2;
    end
  end

  typedef struct {
    logic [2:0]   f;
    logic [31:0]  ia, da, wd;
    logic [3:0]   ws;
    logic [117:0] exp;
  } vec_t;

  int checks = 0, errors = 0;

  function automatic vec_t v(logic [2:0] f, logic [31:0] ia_v, logic [31:0] da_v, logic [31:0] wd_v,
                             logic [3:0] ws_v, logic [6:0] ef, logic [10:0] ea, logic [3:0] es,
                             logic [31:0] ew, logic [31:0] ei, logic [31:0] er);
    vec_t r;
    r.f = f; r.ia = ia_v; r.da = da_v; r.wd = wd_v; r.ws = ws_v;
    r.exp = {ef, ea, es, ew, ei, er};
    return r;
  endfunction

  function automatic logic [117:0] obs1();
    return {ri1, rd1, en1, wen1, rvi1, rvd1, err1 & rvd1, en1 ? addr1 : 11'h0, wstrb1,
            wen1 ? wdata1 : 32'h0, inst1, rdata1};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] f, logic [31:0] ia_v, logic [31:0] da_v, logic [31:0] wd_v, logic [3:0] ws_v);
    {iv, dv, dwen} = f;
    ia = ia_v; da = da_v; dwd = wd_v; dws = ws_v;
  endtask

  localparam logic [31:0] I = 32'h00000013;
  localparam logic [31:0] D = 32'hDEADBEEF;

  vec_t vec [18];
  string gseq;

  initial begin
    vec[0]  = v(3'b100, 32'h100, 32'h0,   32'h0,        4'h0, 7'b1010000, 11'h100, 4'h0, 32'h0,        32'h0, 32'h0);
    vec[1]  = v(3'b100, 32'h100, 32'h0,   32'h0,        4'h0, 7'b0000000, 11'h0,   4'h0, 32'h0,        32'h0, 32'h0);
    vec[2]  = v(3'b100, 32'h100, 32'h0,   32'h0,        4'h0, 7'b1010100, 11'h100, 4'h0, 32'h0,        I,     32'h0);
    vec[3]  = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000000, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[4]  = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000100, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[5]  = v(3'b011, 32'h0,   32'h40,  D,            4'hF, 7'b0111000, 11'h040, 4'hF, D,            I,     32'h0);
    vec[6]  = v(3'b010, 32'h0,   32'h40,  32'h0,        4'h0, 7'b0110010, 11'h040, 4'h0, 32'h0,        I,     32'h0);
    vec[7]  = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000000, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[8]  = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000010, 11'h0,   4'h0, 32'h0,        I,     D);
    vec[9]  = v(3'b011, 32'h0,   32'h42,  32'h12345678, 4'hF, 7'b0100000, 11'h0,   4'h0, 32'h0,        I,     D);
    vec[10] = v(3'b010, 32'h0,   32'h840, 32'h0,        4'h0, 7'b0110011, 11'h040, 4'h0, 32'h0,        I,     32'h0);
    vec[11] = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000000, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[12] = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000010, 11'h0,   4'h0, 32'h0,        I,     D);
    vec[13] = v(3'b010, 32'h0,   32'h41,  32'h0,        4'h0, 7'b0100000, 11'h0,   4'h0, 32'h0,        I,     D);
    vec[14] = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000011, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[15] = v(3'b011, 32'h0,   32'h44,  32'hAAAA5555, 4'h3, 7'b0111000, 11'h044, 4'h3, 32'hAAAA5555, I,     32'h0);
    vec[16] = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000010, 11'h0,   4'h0, 32'h0,        I,     32'h0);
    vec[17] = v(3'b000, 32'h0,   32'h0,   32'h0,        4'h0, 7'b0000000, 11'h0,   4'h0, 32'h0,        I,     32'h0);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {110'h0, obs1()}, 128'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clock); #1;
      drive(vec[i].f, vec[i].ia, vec[i].da, vec[i].wd, vec[i].ws);
      @(negedge clock);
      chk($sformatf("vec%0d", i), {10'h0, obs1()}, {10'h0, vec[i].exp});
    end

    // Both ports hammering: data wins four times, then fetch is forced once.
    begin
      int g = 0;
      gseq = "";
      @(posedge clock); #1;
      drive(3'b110, 32'h100, 32'h40, 32'h0, 4'h0);
      for (int c = 0; c < 80 && g < 10; c++) begin
        @(negedge clock);
        if (rvi1) chk("conc_inst", {96'h0, inst1}, {96'h0, I});
        if (rvd1) chk("conc_rdata", {96'h0, rdata1}, {96'h0, D});
        if (ri1 || rd1) begin
          chk($sformatf("conc_grant%0d", g), {126'h0, ri1, rd1}, {126'h0, (g % 5 == 4), (g % 5 != 4)});
          g++;
        end
        @(posedge clock); #1;
      end
      chk("conc_grant_count", 128'(g), 128'd10);
      drive(3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
      repeat (4) @(posedge clock);
    end

    // READ_LAT=2 back-to-back fetches on the second instance.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      drive({c <= 3, 2'b00}, c < 3 ? 32'h0 : 32'h4, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
      chk($sformatf("lat2_c%0d", c), {124'h0, ri2, rvi2, en2, rd2},
          {124'h0, c == 0 || c == 3, c == 3 || c == 6, c == 0 || c == 3, 1'b0});
      if (c == 3) chk("lat2_inst0", {96'h0, inst2}, {96'h0, 32'h11111111});
      if (c == 3) chk("lat2_addr1", {117'h0, addr2}, {117'h0, 11'h004});
      if (c == 6) chk("lat2_inst1", {96'h0, inst2}, {96'h0, 32'h22222222});
    end

    // Reset while the first instance is waiting on a fetch.
    @(posedge clock); #1;
    drive(3'b100, 32'h100, 32'h0, 32'h0, 4'h0);
    @(negedge clock);
    chk("rst_pre_grant", {127'h0, ri1}, {127'h0, 1'b1});
    @(posedge clock); #1;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1 chk("rst_outputs", {10'h0, obs1()}, 128'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    begin
      int stale = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        stale += int'(rvi1) + int'(rvd1);
      end
      chk("rst_no_stale_resp", 128'(stale), 128'd0);
    end
    @(posedge clock); #1;
    drive(3'b100, 32'h100, 32'h0, 32'h0, 4'h0);
    @(negedge clock);
    chk("post_rst_grant", {115'h0, ri1, en1, addr1}, {115'h0, 1'b1, 1'b1, 11'h100});
    @(posedge clock); #1;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_resp", {95'h0, rvi1, inst1}, {95'h0, 1'b1, I});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
